nyq_decim: RTL and testbench
============================

// Module: nyq_decim
// PURPOSE
//  Accumulate-and-dump decimator directly downstream of the Nyquist filter (NYQ).
//  Takes one signed NYQ_Out sample per clock and averages blocks of 2^k samples,
//  emitting one decimated sample plus a 1-cycle valid strobe per block.
//  Uses the same parameter write bus (WrEn/Addr/PAR_In) as NYQ.
//  Decimation factor and enable are programmed through a control register on that bus.
// PARAMETERS
//  ADDR_WIDTH  11       parameter-bus address width
//  MEM_WIDTH   24       parameter-bus data width
//  IN_WIDTH    24       signed input sample width (= NYQ output width)
//  OUT_WIDTH   24       signed output sample width (must equal IN_WIDTH)
//  MAX_LOG2    5        max log2 decimation factor (M up to 32)
//  CTRL_ADDR   11'h7F0  parameter-bus address of the control register
// PORTS
//  Clk_CI        in   1           system clock, rising edge
//  Rst_RI        in   1           synchronous reset, active high
//  WrEn_SI       in   1           parameter write enable
//  Addr_DI       in   ADDR_WIDTH  parameter write address
//  PAR_In_DI     in   MEM_WIDTH   parameter write data
//  DEC_In_DI     in   IN_WIDTH    signed sample from NYQ, one per cycle
//  DEC_Out_DO    out  OUT_WIDTH   signed decimated sample, registered
//  DEC_Valid_SO  out  1           high for one cycle when DEC_Out_DO is new
// BEHAVIOUR
//  - Ctrl reg: bit0 = EN, bits[3:1] = K (log2 M); other bits ignored. Writes apply
//    only when WrEn_SI=1 && Addr_DI==CTRL_ADDR; all other addresses are ignored.
//  - K > MAX_LOG2 on write is clamped to MAX_LOG2.
//  - Reset (Rst_RI=1 at clk edge): EN=1, K=1, cnt=0, acc=0, DEC_Out_DO=0, DEC_Valid_SO=0.
//  - Reset mid-block discards the partial accumulation.
//  - acc width = IN_WIDTH+MAX_LOG2, signed. cnt counts 0..2^K-1.
//  - States: BYPASS (EN=0 or K=0) and ACCUM (EN=1, K>=1).
//  - ACCUM, cnt<2^K-1: acc<=acc+In; cnt<=cnt+1; DEC_Valid_SO<=0.
//  - ACCUM, cnt==2^K-1: DEC_Out_DO<=(acc+In+R)>>>K (arithmetic shift); DEC_Valid_SO<=1;
//    acc<=0; cnt<=0.
//  - Latency: output and valid appear the cycle after the last sample of the block.
//    Valid period is exactly 2^K cycles.
//  - BYPASS: DEC_Out_DO<=In and DEC_Valid_SO<=1 every cycle (1-cycle latency);
//    acc and cnt are held at 0.
//  - A ctrl write takes effect the next cycle: acc<=0, cnt<=0, DEC_Valid_SO<=0 in the
//    write cycle, and the partial block is discarded.
//  - Sample input on the write cycle is dropped.
//  - Reset has priority over a ctrl write. A ctrl write has priority over a block dump.
//  - Shifted result always fits in OUT_WIDTH (mean of IN_WIDTH values); take the low
//    OUT_WIDTH bits. No saturation is needed.
// CONFIGURATION
//  DEC_ROUND_EN defined: R = 1<<(K-1) (round half up toward +inf).
//  DEC_ROUND_EN undefined: R = 0 (truncate toward -inf).
//  The macro has no effect in BYPASS.
// TESTING
//  1 Reset, then constant In=100 (K=1) -> DEC_Out_DO=100 with valid every 2nd cycle.
//    First valid occurs 2 cycles after reset release.
//  2 Write ctrl=0x5 (EN=1, K=2), then In=1,2,3,4 -> one valid with DEC_Out_DO=3
//    (ROUND_EN) or 2 (no ROUND_EN).
//    Repeat with In=-1,-2,-3,-4 -> -2 (ROUND_EN) or -3 (no ROUND_EN).
//  3 Write K=7, EN=1 with In=0x7FFFFF constant -> clamped to K=5: valid every 32 cycles,
//    DEC_Out_DO=0x7FFFFF. Repeat with In=0x800000 -> 0x800000.
//  4 Write EN=0 -> DEC_Valid_SO=1 every cycle, DEC_Out_DO = previous-cycle In
//    for a random sequence.
//  5 K=2 block mid-way (cnt=2): assert Rst_RI for one cycle -> outputs 0, next valid
//    only after 4 fresh samples. Repeat the mid-block interruption with a ctrl write
//    instead of reset: same result.
//  6 Write to Addr_DI != CTRL_ADDR mid-block -> no change to period or output values.

Source files
------------

// File: rtl/nyq_decim.sv
// Accumulate-and-dump decimator after the Nyquist filter: averages blocks of 2^K samples.
// Latency: one cycle from the last sample of a block (or every sample in bypass) to output.
// Backpressure: none; accepts one sample per cycle and strobes DEC_Valid_SO for one cycle per result.
//
// Ports:
//   Clk_CI, Rst_RI                 clock and synchronous active-high reset
//   WrEn_SI, Addr_DI, PAR_In_DI    shared parameter write bus; only CTRL_ADDR is decoded here
//   DEC_In_DI                      signed input sample, one per cycle
//   DEC_Out_DO, DEC_Valid_SO       registered signed result and its one-cycle strobe
// Control register: bit0 = EN, bits[3:1] = K (log2 of block length, clamped to MAX_LOG2).
// Build option: define DEC_ROUND_EN to round the block mean half-up; otherwise it truncates
// toward -inf. Bypass output is unaffected by this option.
module nyq_decim #(
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    MEM_WIDTH  = 24,
    parameter int                    IN_WIDTH   = 24,
    parameter int                    OUT_WIDTH  = 24,
    parameter int                    MAX_LOG2   = 5,
    parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR  = 11'h7F0
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  WrEn_SI,
    input  logic [ADDR_WIDTH-1:0] Addr_DI,
    input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
    input  logic [IN_WIDTH-1:0]   DEC_In_DI,
    output logic [OUT_WIDTH-1:0]  DEC_Out_DO,
    output logic                  DEC_Valid_SO
);

    localparam int ACC_W = IN_WIDTH + MAX_LOG2;
    localparam int K_W   = 3;
    localparam int CNT_W = (MAX_LOG2 < 1) ? 1 : MAX_LOG2;
    localparam logic [K_W-1:0] K_MAX = K_W'(MAX_LOG2);

    typedef enum logic {
        ST_BYPASS,
        ST_ACCUM
    } state_t;

    state_t                    state_q, state_d;
    logic [K_W-1:0]            k_q, k_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [OUT_WIDTH-1:0]      out_q, out_d;
    logic                      vld_q, vld_d;

    logic                      ctrl_wr;
    logic [K_W-1:0]            k_raw;
    logic [K_W-1:0]            k_wr;
    logic [CNT_W:0]            blk_len;
    logic [CNT_W:0]            cnt_max;
    logic                      blk_last;
    logic signed [ACC_W-1:0]   in_ext;
    logic signed [ACC_W-1:0]   rnd;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   shifted;

    // Control bits above [3:0] and the guard bits of the mean are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{PAR_In_DI[MEM_WIDTH-1:4], shifted[ACC_W-1:OUT_WIDTH]};

    always_comb begin
        ctrl_wr  = WrEn_SI && (Addr_DI == CTRL_ADDR);
        k_raw    = PAR_In_DI[3:1];
        k_wr     = (k_raw > K_MAX) ? K_MAX : k_raw;

        // Block ends when cnt reaches 2^K-1; compare at CNT_W+1 bits so 2^MAX_LOG2 fits.
        blk_len  = (CNT_W+1)'(1) << k_q;
        cnt_max  = blk_len - (CNT_W+1)'(1);
        blk_last = ({1'b0, cnt_q} == cnt_max);

        in_ext   = {{MAX_LOG2{DEC_In_DI[IN_WIDTH-1]}}, DEC_In_DI};
`ifdef DEC_ROUND_EN
        // Half an LSB of the result: 2^(K-1). Only used in accumulate mode, where K >= 1.
        rnd      = (ACC_W'(1) << k_q) >> 1;
`else
        rnd      = '0;
`endif
        // The accumulator has MAX_LOG2 guard bits, so a full block plus rounding cannot wrap.
        sum      = acc_q + in_ext + rnd;
        shifted  = sum >>> k_q;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        out_d   = out_q;
        vld_d   = 1'b0;

        if (ctrl_wr) begin
            // New configuration: discard the partial block and the sample on this cycle.
            k_d     = k_wr;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = (PAR_In_DI[0] && (k_wr != '0)) ? ST_ACCUM : ST_BYPASS;
        end else begin
            case (state_q)
                ST_BYPASS: begin
                    out_d = DEC_In_DI;
                    vld_d = 1'b1;
                    cnt_d = '0;
                    acc_d = '0;
                end
                ST_ACCUM: begin
                    if (blk_last) begin
                        out_d = shifted[OUT_WIDTH-1:0];
                        vld_d = 1'b1;
                        cnt_d = '0;
                        acc_d = '0;
                    end else begin
                        acc_d = acc_q + in_ext;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q <= ST_ACCUM;
            k_q     <= K_W'(1);
            cnt_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    assign DEC_Out_DO   = out_q;
    assign DEC_Valid_SO = vld_q;

endmodule

// File: tb/tb_nyq_decim.sv
// Bench for nyq_decim: directed stimulus with a reference model feeding a scoreboard.
// Latency: expected results are tagged with the clock edge that should produce them.
// Backpressure: none; one stimulus step per clock.
module tb_nyq_decim;

    localparam int AW = 11;
    localparam int MW = 24;
    localparam int IW = 24;
    localparam int OW = 24;
    localparam int ML = 5;
    localparam logic [AW-1:0] CA = 11'h7F0;
`ifdef DEC_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wr;
    logic [AW-1:0]        addr;
    logic [MW-1:0]        par;
    logic signed [IW-1:0] din;
    logic [OW-1:0]        dout;
    logic                 vld;

    always #5 clk = ~clk;

    nyq_decim #(
        .ADDR_WIDTH(AW), .MEM_WIDTH(MW), .IN_WIDTH(IW),
        .OUT_WIDTH(OW), .MAX_LOG2(ML), .CTRL_ADDR(CA)
    ) dut (
        .Clk_CI      (clk),
        .Rst_RI      (rst),
        .WrEn_SI     (wr),
        .Addr_DI     (addr),
        .PAR_In_DI   (par),
        .DEC_In_DI   (din),
        .DEC_Out_DO  (dout),
        .DEC_Valid_SO(vld)
    );

    typedef struct {
        int            cyc;
        logic [OW-1:0] val;
    } exp_t;

    exp_t   sb[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     pcnt    = 0;   // clock edges issued by the driver
    int     ncyc    = 0;   // clock edges seen by the monitor

    bit     m_en;
    int     m_k;
    int     m_cnt;
    longint m_sum;

    // Block mean by floor division, independent of any shift formulation.
    function automatic logic [OW-1:0] mean_of(input longint s, input int k);
        longint m;
        longint n;
        longint q;
        m = longint'(1) << k;
        n = s + (RND ? (m / 2) : 0);
        q = n / m;
        if ((n % m) != 0 && n < 0) q = q - 1;
        return q[OW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit w, input logic [AW-1:0] a,
                        input logic [MW-1:0] p, input logic signed [IW-1:0] d);
        int kk;
        rst  = r;
        wr   = w;
        addr = a;
        par  = p;
        din  = d;
        if (r) begin
            m_en = 1'b1; m_k = 1; m_cnt = 0; m_sum = 0;
        end else if (w && a == CA) begin
            m_en  = p[0];
            kk    = int'(p[3:1]);
            m_k   = (kk > ML) ? ML : kk;
            m_cnt = 0;
            m_sum = 0;
        end else if (!m_en || m_k == 0) begin
            sb.push_back('{pcnt + 1, d});
        end else begin
            m_sum = m_sum + longint'(d);
            m_cnt++;
            if (m_cnt == (1 << m_k)) begin
                sb.push_back('{pcnt + 1, mean_of(m_sum, m_k)});
                m_cnt = 0;
                m_sum = 0;
            end
        end
        @(posedge clk);
        #1;
        pcnt++;
    endtask

    task automatic sample(input logic signed [IW-1:0] d);
        step(1'b0, 1'b0, '0, '0, d);
    endtask

    task automatic wctrl(input logic [MW-1:0] p);
        step(1'b0, 1'b1, CA, p, 24'sh123456);
    endtask

    // Scoreboard monitor: every cycle the strobe must match the model, and values must match on strobe.
    always @(negedge clk) begin
        bit expv;
        ncyc++;
        expv = (sb.size() > 0) && (sb[0].cyc == ncyc);
        n_tests++;
        assert (vld === expv)
        else begin
            n_fail++;
            $error("FAIL mon_vld cyc %0d: observed %b expected %b", ncyc, vld, expv);
        end
        if (expv) begin
            n_tests++;
            assert (dout === sb[0].val)
            else begin
                n_fail++;
                $error("FAIL mon_out cyc %0d: observed %h expected %h", ncyc, dout, sb[0].val);
            end
            void'(sb.pop_front());
        end
    end

    initial begin
        logic signed [IW-1:0] rv;

        // Reset
        step(1'b1, 1'b0, '0, '0, '0);
        step(1'b1, 1'b0, '0, '0, 24'sd55);
        chk("rst_out", dout, '0);
        chk("rst_vld", OW'(vld), '0);

        // Default K=1: first valid two cycles after reset release
        sample(24'sd100);
        chk("t1_first_novld", OW'(vld), '0);
        sample(24'sd100);
        chk("t1_first_vld", OW'(vld), 1);
        chk("t1_first_out", dout, 24'd100);
        for (int i = 0; i < 6; i++) sample(24'sd100);

        // K=2 block means, positive and negative
        wctrl(24'h5);
        chk("t2_wr_novld", OW'(vld), '0);
        sample(24'sd1); sample(24'sd2); sample(24'sd3); sample(24'sd4);
        chk("t2_pos_vld", OW'(vld), 1);
        chk("t2_pos_out", dout, RND ? 24'd3 : 24'd2);
        sample(-24'sd1); sample(-24'sd2); sample(-24'sd3); sample(-24'sd4);
        chk("t2_neg_out", dout, RND ? 24'hFFFFFE : 24'hFFFFFD);

        // K=7 requested, clamped to 5: full-scale positive and negative
        wctrl(24'h0F);
        for (int i = 0; i < 64; i++) sample(24'sh7FFFFF);
        chk("t3_pos_out", dout, 24'h7FFFFF);
        for (int i = 0; i < 64; i++) sample(24'sh800000);
        chk("t3_neg_out", dout, 24'h800000);

        // EN=0 bypass on random data
        wctrl(24'h0);
        for (int i = 0; i < 20; i++) begin
            rv = IW'($urandom());
            sample(rv);
            chk("t4_byp_out", dout, rv);
        end

        // EN=1, K=0 also bypasses
        wctrl(24'h1);
        sample(24'sh0ABCDE);
        chk("t4_k0_out", dout, 24'h0ABCDE);
        sample(-24'sd7);

        // Reset mid-block discards partial sum
        wctrl(24'h5);
        sample(24'sd10); sample(24'sd20);
        step(1'b1, 1'b0, '0, '0, 24'sd99);
        chk("t5_rst_out", dout, '0);
        chk("t5_rst_vld", OW'(vld), '0);
        wctrl(24'h5);
        sample(24'sd4); sample(24'sd8); sample(24'sd12);
        chk("t5_rst_novld", OW'(vld), '0);
        sample(24'sd16);
        chk("t5_rst_blk", dout, 24'd10);

        // Ctrl write mid-block discards partial sum
        sample(24'sd10); sample(24'sd20);
        wctrl(24'h5);
        chk("t5_wr_vld", OW'(vld), '0);
        sample(24'sd4); sample(24'sd8); sample(24'sd12);
        chk("t5_wr_novld", OW'(vld), '0);
        sample(24'sd16);
        chk("t5_wr_blk", dout, 24'd10);

        // Writes to other addresses do not disturb the block
        sample(24'sd1); sample(24'sd2);
        step(1'b0, 1'b1, 11'h7EF, 24'h0, 24'sd3);
        chk("t6_other_novld", OW'(vld), '0);
        sample(24'sd6);
        chk("t6_other_out", dout, 24'd3);
        step(1'b0, 1'b1, 11'h3F0, 24'h0, 24'sd5);
        sample(24'sd5); sample(24'sd5); sample(24'sd5);
        chk("t6_other2_out", dout, 24'd5);

        // Drain and confirm every expected result was seen
        wctrl(24'h0);
        sample(24'sd1);
        sample(24'sd2);
        @(negedge clk);
        #1;
        chk("sb_empty", OW'(sb.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
